// File: rtl/fsm_serial_tx.sv
// One-hot Moore serial transmitter: start bit, NBITS data bits LSB first, optional parity bit, stop bit.
// Define FSM_SERIAL_TX_PARITY_EN to add an even-parity slot after the last data bit.
module fsm_serial_tx #(
    parameter int unsigned NBITS    = 8,
    parameter int unsigned BAUD_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_msg,
    output logic             out,
    output logic [3:0]       state
);
    localparam int unsigned CW = $clog2(NBITS + 2);
    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
`ifdef FSM_SERIAL_TX_PARITY_EN
    localparam int unsigned LAST = NBITS + 1;
`else
    localparam int unsigned LAST = NBITS;
`endif

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_q, bit_d;
    logic [BW-1:0]    baud_q, baud_d;
    logic             tick;
    logic             accept;
`ifdef FSM_SERIAL_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign tick  = (baud_q == BW'(BAUD_DIV - 1));
    assign state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
`ifdef FSM_SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
`ifdef FSM_SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
`ifdef FSM_SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        in_rdy  = 1'b0;
        out     = 1'b1;

        case (state_q)
            IDLE: begin
                in_rdy = 1'b1;
            end
            START: begin
                out = 1'b0;
                if (tick) begin
                    state_d = DATA;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
`ifdef FSM_SERIAL_TX_PARITY_EN
                out = (bit_q == CW'(NBITS)) ? par_q : shreg_q[0];
`else
                out = shreg_q[0];
`endif
                if (tick) begin
                    baud_d  = '0;
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + CW'(1);
`ifdef FSM_SERIAL_TX_PARITY_EN
                    // Parity is folded in as each data bit leaves the shifter.
                    if (bit_q < CW'(NBITS))
                        par_d = par_q ^ shreg_q[0];
`endif
                    if (bit_q == CW'(LAST - 1))
                        state_d = STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                in_rdy = tick;
                if (tick) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                // Corrupted one-hot: recover to IDLE without accepting a word.
                state_d = IDLE;
                bit_d   = '0;
                baud_d  = '0;
            end
        endcase

        accept = in_val && in_rdy;
        if (accept) begin
            state_d = START;
            shreg_d = in_msg;
            bit_d   = '0;
            baud_d  = '0;
`ifdef FSM_SERIAL_TX_PARITY_EN
            par_d   = 1'b0;
`endif
        end
    end
endmodule
